// File: rtl/mem_arb_pkg.sv
// -----------------------------------------------------------------------------
// mem_arb_pkg
// Shared types and constants for the unified memory port arbiter.
//   arb_state_t : transaction state (idle / memory access in flight / response)
//   ARB_FIXED   : fixed-priority arbitration, channel 0 highest
//   ARB_RR      : round-robin arbitration
//   idx_width() : width of a channel index, never less than one bit
// -----------------------------------------------------------------------------
package mem_arb_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE = 2'd0,
    ARB_BUSY = 2'd1,
    ARB_RESP = 2'd2
  } arb_state_t;

  localparam int ARB_FIXED = 0;
  localparam int ARB_RR    = 1;

  // A single-channel arbiter still needs a one-bit index register.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/mem_port_arbiter_if.sv
// -----------------------------------------------------------------------------
// mem_port_arbiter_if
// Bundles the requester-side handshake and the memory-side port of the arbiter.
//   req_valid/req_we/req_addr/req_wdata : per-channel requests (flattened slices)
//   req_ready                           : one-hot accept strobe
//   rsp_valid/rsp_rdata                 : one-hot completion strobe and read data
//   mem_en/mem_we/mem_addr/mem_wdata    : shared fixed-latency memory port
//   mem_rdata                           : memory read data
//   busy                                : arbiter has a transaction in flight
// Modports: slave = the arbiter, master = whatever drives requests / memory.
// -----------------------------------------------------------------------------
interface mem_port_arbiter_if #(
  parameter int N_CH   = 2,
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16
);

  logic [N_CH-1:0]        req_valid;
  logic [N_CH-1:0]        req_we;
  logic [N_CH*ADDR_W-1:0] req_addr;
  logic [N_CH*DATA_W-1:0] req_wdata;
  logic [N_CH-1:0]        req_ready;
  logic [N_CH-1:0]        rsp_valid;
  logic [DATA_W-1:0]      rsp_rdata;
  logic                   mem_en;
  logic                   mem_we;
  logic [ADDR_W-1:0]      mem_addr;
  logic [DATA_W-1:0]      mem_wdata;
  logic [DATA_W-1:0]      mem_rdata;
  logic                   busy;

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, mem_rdata,
    output req_ready, rsp_valid, rsp_rdata,
    output mem_en, mem_we, mem_addr, mem_wdata, busy
  );

  modport master (
    output req_valid, req_we, req_addr, req_wdata, mem_rdata,
    input  req_ready, rsp_valid, rsp_rdata,
    input  mem_en, mem_we, mem_addr, mem_wdata, busy
  );

endinterface

// File: rtl/mem_arb_grant.sv
// -----------------------------------------------------------------------------
// mem_arb_grant
// Purely combinational grant picker.
//   req       : request vector, one bit per channel
//   start     : index of the last channel granted (round-robin pointer)
//   rr_mode   : 1 = search from start+1 upward with wrap, 0 = search from 0
//   grant     : one-hot grant (all zero when nothing requests)
//   grant_idx : binary index of the granted channel
//   any       : at least one channel requests
// -----------------------------------------------------------------------------
module mem_arb_grant
  import mem_arb_pkg::*;
#(
  parameter  int N_CH  = 2,
  localparam int IDX_W = idx_width(N_CH)
) (
  input  logic [N_CH-1:0]  req,
  input  logic [IDX_W-1:0] start,
  input  logic             rr_mode,
  output logic [N_CH-1:0]  grant,
  output logic [IDX_W-1:0] grant_idx,
  output logic             any
);

  int unsigned base_idx;
  int unsigned cand;

  // Both modes are the same rotating search; fixed priority simply always
  // begins at channel 0 while round-robin begins just after the last winner.
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    any       = 1'b0;
    cand      = 0;
    base_idx  = rr_mode ? ((int'(start) + 1) % N_CH) : 0;
    for (int k = 0; k < N_CH; k++) begin
      cand = (base_idx + k) % N_CH;
      if (!any && req[cand]) begin
        any             = 1'b1;
        grant[cand]     = 1'b1;
        grant_idx       = IDX_W'(cand);
      end
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// mem_port_arbiter
// Shares one fixed-latency memory port among N_CH requesters (instruction
// fetch, data access, DMA). Only one transaction is in flight at a time:
// accept in IDLE, hold the memory port for MEM_LAT cycles in BUSY, then pulse
// the owner's response strobe for one cycle in RESP.
// Parameters:
//   N_CH     number of requester channels (>= 1)
//   ADDR_W   address width
//   DATA_W   data width
//   MEM_LAT  memory latency in cycles (>= 1)
//   ARB_MODE ARB_FIXED or ARB_RR
// Ports:
//   clk  clock, all state on the rising edge
//   rst  asynchronous, active-low reset
//   bus  mem_port_arbiter_if.slave (requests, responses, memory port, busy)
// -----------------------------------------------------------------------------
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int N_CH     = 2,
  parameter int ADDR_W   = 16,
  parameter int DATA_W   = 16,
  parameter int MEM_LAT  = 4,
  parameter int ARB_MODE = ARB_RR
) (
  input  logic               clk,
  input  logic               rst,
  mem_port_arbiter_if.slave  bus
);

  localparam int   IDX_W = idx_width(N_CH);
  localparam int   CNT_W = $clog2(MEM_LAT + 1);
  localparam logic RR_EN = (ARB_MODE == ARB_RR);

  // Reject configurations that cannot work at elaboration time.
  generate
    if (N_CH < 1) begin : g_bad_nch
      $error("mem_port_arbiter: N_CH must be at least 1");
    end
    if (MEM_LAT < 1) begin : g_bad_lat
      $error("mem_port_arbiter: MEM_LAT must be at least 1");
    end
    if (ARB_MODE != ARB_FIXED && ARB_MODE != ARB_RR) begin : g_bad_mode
      $error("mem_port_arbiter: ARB_MODE must be ARB_FIXED or ARB_RR");
    end
  endgenerate

  arb_state_t        state;
  arb_state_t        next_state;
  logic [CNT_W-1:0]  cnt;
  logic [IDX_W-1:0]  owner;
  logic [IDX_W-1:0]  rr_ptr;
  logic              lat_we;
  logic [ADDR_W-1:0] lat_addr;
  logic [DATA_W-1:0] lat_wdata;
  logic [DATA_W-1:0] rdata_q;

  logic [N_CH-1:0]   grant;
  logic [IDX_W-1:0]  grant_idx;
  logic              grant_any;
  logic              accept;
  logic              cnt_done;

  mem_arb_grant #(
    .N_CH (N_CH)
  ) u_grant (
    .req       (bus.req_valid),
    .start     (rr_ptr),
    .rr_mode   (RR_EN),
    .grant     (grant),
    .grant_idx (grant_idx),
    .any       (grant_any)
  );

  // Requests are only looked at in IDLE; anything raised while a transaction
  // is in flight simply waits until the arbiter comes back to IDLE.
  assign accept   = (state == ARB_IDLE) && grant_any;
  assign cnt_done = (cnt == '0);

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= ARB_IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state logic: IDLE -> BUSY on accept, BUSY -> RESP when the latency
  // counter has run out, RESP always returns to IDLE after one cycle.
  always_comb begin
    next_state = state;
    case (state)
      ARB_IDLE: if (grant_any) next_state = ARB_BUSY;
      ARB_BUSY: if (cnt_done)  next_state = ARB_RESP;
      ARB_RESP: next_state = ARB_IDLE;
      default:  next_state = ARB_IDLE;
    endcase
  end

  // Transaction datapath. The counter is loaded with MEM_LAT-1 so that it
  // reaches zero in the last BUSY cycle, which is exactly the cycle in which
  // the memory presents read data. Writes leave the response data untouched.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt       <= '0;
      owner     <= '0;
      rr_ptr    <= IDX_W'(N_CH - 1);
      lat_we    <= 1'b0;
      lat_addr  <= '0;
      lat_wdata <= '0;
      rdata_q   <= '0;
    end else if (accept) begin
      owner     <= grant_idx;
      rr_ptr    <= grant_idx;
      lat_we    <= bus.req_we[grant_idx];
      lat_addr  <= bus.req_addr[grant_idx*ADDR_W +: ADDR_W];
      lat_wdata <= bus.req_wdata[grant_idx*DATA_W +: DATA_W];
      cnt       <= CNT_W'(MEM_LAT - 1);
    end else if (state == ARB_BUSY) begin
      if (!cnt_done) begin
        cnt <= cnt - 1'b1;
      end else if (!lat_we) begin
        rdata_q <= bus.mem_rdata;
      end
    end
  end

  // Output decode. The memory-side fields are forced to zero outside BUSY so
  // the port is quiet between accesses. req_ready is also masked by reset so
  // that every output is low while reset is held, even with requests pending.
  always_comb begin
    bus.req_ready = '0;
    bus.rsp_valid = '0;
    bus.mem_en    = 1'b0;
    bus.mem_we    = 1'b0;
    bus.mem_addr  = '0;
    bus.mem_wdata = '0;
    bus.busy      = (state != ARB_IDLE);
    case (state)
      ARB_IDLE: begin
        if (rst) bus.req_ready = grant;
      end
      ARB_BUSY: begin
        bus.mem_en    = 1'b1;
        bus.mem_we    = lat_we;
        bus.mem_addr  = lat_addr;
        bus.mem_wdata = lat_wdata;
      end
      ARB_RESP: begin
        bus.rsp_valid[owner] = 1'b1;
      end
      default: begin
        bus.busy = 1'b0;
      end
    endcase
  end

  assign bus.rsp_rdata = rdata_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mem_port_arbiter
// Drives two arbiter instances side by side with random requesters:
//   dut0 : 4 channels, round-robin, MEM_LAT = 4
//   dut1 : 4 channels, fixed priority, MEM_LAT = 1
// A transaction-level reference model predicts every output each cycle from
// the accept time of the current transaction and the arbitration rules.
// -----------------------------------------------------------------------------
module tb_mem_port_arbiter;
  import mem_arb_pkg::*;

  localparam int N    = 4;
  localparam int AW   = 16;
  localparam int DW   = 16;
  localparam int ND   = 2;
  localparam int LAT0 = 4;
  localparam int LAT1 = 1;
  localparam int NCYC = 2200;

  typedef struct packed {
    logic [N-1:0]  req_ready;
    logic [N-1:0]  rsp_valid;
    logic [DW-1:0] rsp_rdata;
    logic          mem_en;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic          busy;
  } obs_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  mem_port_arbiter_if #(.N_CH(N), .ADDR_W(AW), .DATA_W(DW)) bus0 ();
  mem_port_arbiter_if #(.N_CH(N), .ADDR_W(AW), .DATA_W(DW)) bus1 ();

  mem_port_arbiter #(
    .N_CH(N), .ADDR_W(AW), .DATA_W(DW), .MEM_LAT(LAT0), .ARB_MODE(ARB_RR)
  ) dut0 (
    .clk (clk),
    .rst (rst),
    .bus (bus0.slave)
  );

  mem_port_arbiter #(
    .N_CH(N), .ADDR_W(AW), .DATA_W(DW), .MEM_LAT(LAT1), .ARB_MODE(ARB_FIXED)
  ) dut1 (
    .clk (clk),
    .rst (rst),
    .bus (bus1.slave)
  );

  // Requester and memory stimulus, one set per DUT.
  logic [N-1:0]  req_valid [ND];
  logic [N-1:0]  req_we    [ND];
  logic [AW-1:0] req_addr  [ND][N];
  logic [DW-1:0] req_wdata [ND][N];
  logic [DW-1:0] mem_rdata [ND];

  always_comb begin
    bus0.req_valid = req_valid[0];
    bus0.req_we    = req_we[0];
    bus0.mem_rdata = mem_rdata[0];
    bus1.req_valid = req_valid[1];
    bus1.req_we    = req_we[1];
    bus1.mem_rdata = mem_rdata[1];
    for (int i = 0; i < N; i++) begin
      bus0.req_addr[i*AW +: AW]  = req_addr[0][i];
      bus0.req_wdata[i*DW +: DW] = req_wdata[0][i];
      bus1.req_addr[i*AW +: AW]  = req_addr[1][i];
      bus1.req_wdata[i*DW +: DW] = req_wdata[1][i];
    end
  end

  obs_t obs0, obs1;

  always_comb begin
    obs0.req_ready = bus0.req_ready;
    obs0.rsp_valid = bus0.rsp_valid;
    obs0.rsp_rdata = bus0.rsp_rdata;
    obs0.mem_en    = bus0.mem_en;
    obs0.mem_we    = bus0.mem_we;
    obs0.mem_addr  = bus0.mem_addr;
    obs0.mem_wdata = bus0.mem_wdata;
    obs0.busy      = bus0.busy;
    obs1.req_ready = bus1.req_ready;
    obs1.rsp_valid = bus1.rsp_valid;
    obs1.rsp_rdata = bus1.rsp_rdata;
    obs1.mem_en    = bus1.mem_en;
    obs1.mem_we    = bus1.mem_we;
    obs1.mem_addr  = bus1.mem_addr;
    obs1.mem_wdata = bus1.mem_wdata;
    obs1.busy      = bus1.busy;
  end

  // Reference model state: a transaction is described by its accept cycle,
  // owner and request contents; all outputs follow from elapsed cycles.
  bit            m_busy     [ND];
  int            m_acc      [ND];
  int            m_owner    [ND];
  bit            m_we       [ND];
  logic [AW-1:0] m_addr     [ND];
  logic [DW-1:0] m_wdata    [ND];
  int            m_rr       [ND];
  logic [DW-1:0] m_rdata    [ND];
  bit            m_accepted [ND][N];

  int cyc;
  int n_pass;
  int n_checks;
  int stim_mode;
  int rst_cnt;
  bit rst_done;

  function automatic int lat_of(input int d);
    return (d == 0) ? LAT0 : LAT1;
  endfunction

  function automatic int mode_of(input int d);
    return (d == 0) ? ARB_RR : ARB_FIXED;
  endfunction

  function automatic obs_t get_obs(input int d);
    return (d == 0) ? obs0 : obs1;
  endfunction

  // Winner among the currently valid channels, or -1 if none.
  function automatic int pick(input int d);
    int idx;
    if (mode_of(d) == ARB_FIXED) begin
      for (int i = 0; i < N; i++) if (req_valid[d][i]) return i;
    end else begin
      for (int s = 1; s <= N; s++) begin
        idx = (m_rr[d] + s) % N;
        if (req_valid[d][idx]) return idx;
      end
    end
    return -1;
  endfunction

  task automatic check_output(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("[TB] FAIL %s got=%0h expected=%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Requesters: a pending request is held unchanged until accepted; in the
  // random mode it may also be withdrawn before being accepted. In the
  // contention mode every idle channel requests again at once.
  task automatic apply_stimulus(input int d);
    bit was_valid;
    for (int ch = 0; ch < N; ch++) begin
      was_valid = req_valid[d][ch];
      if (m_accepted[d][ch]) begin
        req_valid[d][ch] = 1'b0;
        was_valid = 1'b0;
      end else if (was_valid && stim_mode == 0 && $urandom_range(11) == 0) begin
        req_valid[d][ch] = 1'b0;
      end
      if (!was_valid && !req_valid[d][ch] && (stim_mode == 1 || $urandom_range(3) == 0)) begin
        req_valid[d][ch] = 1'b1;
        req_we[d][ch]    = 1'($urandom_range(1));
        req_addr[d][ch]  = AW'($urandom);
        req_wdata[d][ch] = DW'($urandom);
      end
    end
    mem_rdata[d] = DW'($urandom);
  endtask

  task automatic model_step(input int d);
    obs_t          o;
    int            lat;
    int            k;
    int            g;
    logic [N-1:0]  e_ready;
    logic [N-1:0]  e_rsp;
    logic          e_en;
    logic          e_busy;
    logic          e_we;
    logic [AW-1:0] e_addr;
    logic [DW-1:0] e_wdata;
    logic [DW-1:0] next_rdata;
    bit            check_bus;
    string         p;

    o = get_obs(d);
    lat = lat_of(d);
    p = $sformatf("dut%0d.", d);
    k = 0;
    g = -1;
    e_ready = '0;
    e_rsp = '0;
    e_en = 1'b0;
    e_busy = 1'b0;
    e_we = 1'b0;
    e_addr = '0;
    e_wdata = '0;
    check_bus = 1'b0;
    for (int ch = 0; ch < N; ch++) m_accepted[d][ch] = 1'b0;

    if (rst !== 1'b1) begin
      m_busy[d]  = 1'b0;
      m_rr[d]    = N - 1;
      m_rdata[d] = '0;
      check_bus  = 1'b1;
    end else if (!m_busy[d]) begin
      g = pick(d);
      if (g >= 0) begin
        e_ready[g] = 1'b1;
        m_accepted[d][g] = 1'b1;
      end
    end else begin
      k = cyc - m_acc[d];
      e_busy = 1'b1;
      if (k <= lat) begin
        e_en      = 1'b1;
        check_bus = 1'b1;
        e_we      = m_we[d];
        e_addr    = m_addr[d];
        e_wdata   = m_wdata[d];
      end else begin
        e_rsp[m_owner[d]] = 1'b1;
      end
    end

    next_rdata = m_rdata[d];
    if (rst === 1'b1 && m_busy[d] && k == lat && !m_we[d]) next_rdata = mem_rdata[d];

    check_output({p, "req_ready"}, 32'(o.req_ready), 32'(e_ready));
    check_output({p, "rsp_valid"}, 32'(o.rsp_valid), 32'(e_rsp));
    check_output({p, "mem_en"},    32'(o.mem_en),    32'(e_en));
    check_output({p, "busy"},      32'(o.busy),      32'(e_busy));
    check_output({p, "rsp_rdata"}, 32'(o.rsp_rdata), 32'(m_rdata[d]));
    if (check_bus) begin
      check_output({p, "mem_we"},    32'(o.mem_we),    32'(e_we));
      check_output({p, "mem_addr"},  32'(o.mem_addr),  32'(e_addr));
      check_output({p, "mem_wdata"}, 32'(o.mem_wdata), 32'(e_wdata));
    end

    if (g >= 0) begin
      m_busy[d]  = 1'b1;
      m_acc[d]   = cyc;
      m_owner[d] = g;
      m_we[d]    = req_we[d][g];
      m_addr[d]  = req_addr[d][g];
      m_wdata[d] = req_wdata[d][g];
      m_rr[d]    = g;
    end else if (m_busy[d] && k == lat + 1) begin
      m_busy[d] = 1'b0;
    end
    m_rdata[d] = next_rdata;
  endtask

  // Checks taken right after reset is asserted in the middle of a cycle.
  task automatic check_async_reset(input int d);
    obs_t  o;
    string p;
    o = get_obs(d);
    p = $sformatf("dut%0d.async_", d);
    check_output({p, "mem_en"},    32'(o.mem_en),    32'd0);
    check_output({p, "busy"},      32'(o.busy),      32'd0);
    check_output({p, "rsp_valid"}, 32'(o.rsp_valid), 32'd0);
    check_output({p, "req_ready"}, 32'(o.req_ready), 32'd0);
    check_output({p, "rsp_rdata"}, 32'(o.rsp_rdata), 32'd0);
  endtask

  initial begin
    n_pass    = 0;
    n_checks  = 0;
    cyc       = 0;
    stim_mode = 0;
    rst_cnt   = 3;
    rst_done  = 1'b0;
    for (int d = 0; d < ND; d++) begin
      req_valid[d] = '0;
      req_we[d]    = '0;
      mem_rdata[d] = '0;
      m_busy[d]    = 1'b0;
      m_acc[d]     = 0;
      m_owner[d]   = 0;
      m_rr[d]      = N - 1;
      m_rdata[d]   = '0;
      for (int ch = 0; ch < N; ch++) begin
        req_addr[d][ch]   = '0;
        req_wdata[d][ch]  = '0;
        m_accepted[d][ch] = 1'b0;
      end
    end
    rst = 1'b0;

    for (int c = 0; c < NCYC; c++) begin
      @(posedge clk);
      cyc++;
      #1;
      if (rst_cnt > 0) begin
        rst_cnt--;
        if (rst_cnt == 0) rst = 1'b1;
      end
      stim_mode = (c >= 800 && c < 1300) ? 1 : 0;
      apply_stimulus(0);
      apply_stimulus(1);
      // Abandon dut0's transaction in its second memory cycle.
      if (!rst_done && c >= 900 && rst === 1'b1 && m_busy[0] && (cyc - m_acc[0]) == 2) begin
        #1 rst = 1'b0;
        #1;
        check_async_reset(0);
        check_async_reset(1);
        rst_done = 1'b1;
        rst_cnt  = 3;
      end
      @(negedge clk);
      model_step(0);
      model_step(1);
    end

    check_output("reset_trigger_reached", 32'(rst_done), 32'd1);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
